// File: rtl/mem_pkg.sv
// Shared types, default sizes and the address range check for the unified memory.
package mem_pkg;

    typedef enum logic {StClear, StRun} state_e;

    localparam int unsigned DefWordSize = 16;
    localparam int unsigned DefAddrBits = 8;

    // An address is in range when every bit above the implemented index bits is 0.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned abits);
        return (addr >> abits) == 32'd0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single write port, two registered read ports with write-first bypass and a
// synchronous zero load for out-of-range or reset reads.
module mem_array #(
    parameter int unsigned Width = 16,
    parameter int unsigned ABits = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ABits-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             a_en_i,
    input  logic             a_zero_i,
    input  logic [ABits-1:0] a_addr_i,
    output logic [Width-1:0] a_data_o,
    input  logic             b_en_i,
    input  logic             b_zero_i,
    input  logic [ABits-1:0] b_addr_i,
    output logic [Width-1:0] b_data_o
);
    localparam int unsigned Depth = 2 ** ABits;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] a_data_q, b_data_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (a_zero_i) begin
            a_data_q <= '0;
        end else if (a_en_i) begin
            a_data_q <= (we_i && waddr_i == a_addr_i) ? wdata_i : mem_q[a_addr_i];
        end
        if (b_zero_i) begin
            b_data_q <= '0;
        end else if (b_en_i) begin
            b_data_q <= (we_i && waddr_i == b_addr_i) ? wdata_i : mem_q[b_addr_i];
        end
    end

    assign a_data_o = a_data_q;
    assign b_data_o = b_data_q;

endmodule

// File: rtl/memory_unit.sv
// Unified instruction/data memory: post-reset clear sequence, fetch and load/store
// ports, and a loader port that wins over processor stores.
module memory_unit
    import mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DefWordSize,
    parameter int unsigned ADDR_BITS = DefAddrBits
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [WORD_SIZE-1:0] InstAddr,
    output logic [WORD_SIZE-1:0] InstOut,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataIn,
    input  logic                 WriteData,
    input  logic                 ReadData,
    output logic [WORD_SIZE-1:0] DataOut,
    input  logic                 LoadEn,
    input  logic [ADDR_BITS-1:0] LoadAddr,
    input  logic [WORD_SIZE-1:0] LoadData,
    output logic                 Ready,
    output logic                 AddrFault,
    output logic                 Conflict
);
    state_e               state_q;
    logic [ADDR_BITS-1:0] clr_cnt_q;
    logic                 addr_fault_q, conflict_q;

    logic                 run, proc_en, data_ok, inst_ok;
    logic                 clear_wr, load_wr, proc_st;
    logic                 we;
    logic [ADDR_BITS-1:0] waddr;
    logic [WORD_SIZE-1:0] wdata;
    logic                 rd_en, rd_zero, if_zero;

    always_comb begin
        run      = (state_q == StRun) && !Reset;
        proc_en  = run && Enable;
        data_ok  = in_range(32'(DataAddr), ADDR_BITS);
        inst_ok  = in_range(32'(InstAddr), ADDR_BITS);
        clear_wr = (state_q == StClear) && !Reset;
        load_wr  = run && LoadEn;
        proc_st  = proc_en && WriteData && data_ok;

        // Write port priority: clear, then loader, then processor store.
        we    = clear_wr || load_wr || proc_st;
        waddr = DataAddr[ADDR_BITS-1:0];
        wdata = DataIn;
        if (clear_wr) begin
            waddr = clr_cnt_q;
            wdata = '0;
        end else if (load_wr) begin
            waddr = LoadAddr;
            wdata = LoadData;
        end

        rd_en   = proc_en && ReadData;
        rd_zero = Reset || (rd_en && !data_ok);
        if_zero = Reset || (proc_en && !inst_ok);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            addr_fault_q <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    clr_cnt_q    <= clr_cnt_q + 1'b1;
                    addr_fault_q <= 1'b0;
                    conflict_q   <= 1'b0;
                    if (&clr_cnt_q) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    addr_fault_q <= proc_en &&
                                    (!inst_ok || ((ReadData || WriteData) && !data_ok));
                    conflict_q   <= proc_st && LoadEn;
                end
            endcase
        end
    end

    mem_array #(
        .Width (WORD_SIZE),
        .ABits (ADDR_BITS)
    ) u_array (
        .clk_i    (Clock),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .a_en_i   (rd_en),
        .a_zero_i (rd_zero),
        .a_addr_i (DataAddr[ADDR_BITS-1:0]),
        .a_data_o (DataOut),
        .b_en_i   (proc_en),
        .b_zero_i (if_zero),
        .b_addr_i (InstAddr[ADDR_BITS-1:0]),
        .b_data_o (InstOut)
    );

    assign Ready     = (state_q == StRun);
    assign AddrFault = addr_fault_q;
    assign Conflict  = conflict_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: clear timing, store/load, forwarding, faults,
// loader conflicts, enable gating and mid-run reset.
module tb_memory_unit;
    logic        Clock = 1'b0;
    logic        Reset, Enable, WriteData, ReadData, LoadEn;
    logic [15:0] InstAddr, DataAddr, DataIn, LoadData;
    logic [7:0]  LoadAddr;
    logic [15:0] InstOut, DataOut;
    logic        Ready, AddrFault, Conflict;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    memory_unit #(
        .WORD_SIZE (16),
        .ADDR_BITS (8)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .InstAddr  (InstAddr),
        .InstOut   (InstOut),
        .DataAddr  (DataAddr),
        .DataIn    (DataIn),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .DataOut   (DataOut),
        .LoadEn    (LoadEn),
        .LoadAddr  (LoadAddr),
        .LoadData  (LoadData),
        .Ready     (Ready),
        .AddrFault (AddrFault),
        .Conflict  (Conflict)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        Enable    = 1'b1;
        WriteData = 1'b0;
        ReadData  = 1'b0;
        LoadEn    = 1'b0;
        DataIn    = 16'h0000;
        DataAddr  = 16'h0000;
        LoadAddr  = 8'h00;
        LoadData  = 16'h0000;
    endtask

    task automatic test_reset();
        int bad;
        idle();
        InstAddr = 16'h0000;
        Reset    = 1'b1;
        step();
        n_vec++;
        if (Ready !== 1'b0 || InstOut !== 16'h0 || DataOut !== 16'h0 ||
            AddrFault !== 1'b0 || Conflict !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: Ready=%b InstOut=%h DataOut=%h AF=%b C=%b expected all 0",
                     Ready, InstOut, DataOut, AddrFault, Conflict);
        end
        Reset = 1'b0;
        // Requests during the clear sequence must be ignored.
        ReadData = 1'b1; WriteData = 1'b1; DataAddr = 16'h0020; DataIn = 16'hEEEE;
        LoadEn = 1'b1; LoadAddr = 8'h20; LoadData = 16'hFFFF; InstAddr = 16'h0020;
        bad = 0;
        for (int i = 1; i < 256; i++) begin
            step();
            if (Ready !== 1'b0 || InstOut !== 16'h0 || DataOut !== 16'h0 ||
                AddrFault !== 1'b0 || Conflict !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL clear_quiet: %0d bad cycles before edge R+256, expected 0", bad);
        end
        idle();
        InstAddr = 16'h0000;
        step();
        n_vec++;
        if (Ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_rise: Ready=%b after edge R+256, expected 1", Ready);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            ReadData = 1'b1;
            DataAddr = 16'(a);
            InstAddr = 16'(a);
            step();
            if (DataOut !== 16'h0 || InstOut !== 16'h0 || AddrFault !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL cleared_sweep: %0d addresses nonzero, expected 0", bad);
        end
        idle();
        InstAddr = 16'h0000;
    endtask

    task automatic test_store_load();
        idle();
        WriteData = 1'b1; DataAddr = 16'h0012; DataIn = 16'hBEEF;
        step();
        idle();
        ReadData = 1'b1; DataAddr = 16'h0012;
        step();
        n_vec++;
        if (DataOut !== 16'hBEEF || AddrFault !== 1'b0) begin
            n_err++;
            $display("FAIL store_load: DataOut=%h AF=%b expected BEEF AF=0", DataOut, AddrFault);
        end
        idle();
        DataAddr = 16'h0013;
        step();
        n_vec++;
        if (DataOut !== 16'hBEEF) begin
            n_err++;
            $display("FAIL dataout_hold: DataOut=%h expected BEEF", DataOut);
        end
    endtask

    task automatic test_forward();
        idle();
        WriteData = 1'b1; DataAddr = 16'h0005; DataIn = 16'h0BAD;
        step();
        DataIn = 16'h1234; InstAddr = 16'h0005;
        step();
        n_vec++;
        if (InstOut !== 16'h1234 || DataOut !== 16'hBEEF) begin
            n_err++;
            $display("FAIL fetch_forward: InstOut=%h DataOut=%h expected 1234 BEEF",
                     InstOut, DataOut);
        end
        DataIn = 16'h0BAD; InstAddr = 16'h0000;
        step();
        ReadData = 1'b1; DataIn = 16'h1234;
        step();
        n_vec++;
        if (DataOut !== 16'h1234) begin
            n_err++;
            $display("FAIL load_forward: DataOut=%h expected 1234", DataOut);
        end
        idle();
        LoadEn = 1'b1; LoadAddr = 8'h05; LoadData = 16'h2222;
        InstAddr = 16'h0005; ReadData = 1'b1; DataAddr = 16'h0005;
        step();
        n_vec++;
        if (InstOut !== 16'h2222 || DataOut !== 16'h2222) begin
            n_err++;
            $display("FAIL loader_forward: InstOut=%h DataOut=%h expected 2222 2222",
                     InstOut, DataOut);
        end
        idle();
        InstAddr = 16'h0000;
    endtask

    task automatic test_addr_fault();
        idle();
        WriteData = 1'b1; DataAddr = 16'h0000; DataIn = 16'h1111;
        step();
        idle();
        ReadData = 1'b1; DataAddr = 16'h0100;
        step();
        n_vec++;
        if (DataOut !== 16'h0000 || AddrFault !== 1'b1) begin
            n_err++;
            $display("FAIL oor_load: DataOut=%h AF=%b expected 0000 AF=1", DataOut, AddrFault);
        end
        idle();
        step();
        n_vec++;
        if (AddrFault !== 1'b0) begin
            n_err++;
            $display("FAIL fault_pulse: AF=%b expected 0", AddrFault);
        end
        WriteData = 1'b1; DataAddr = 16'h0100; DataIn = 16'hAAAA;
        step();
        n_vec++;
        if (AddrFault !== 1'b1) begin
            n_err++;
            $display("FAIL oor_store_fault: AF=%b expected 1", AddrFault);
        end
        idle();
        ReadData = 1'b1; DataAddr = 16'h0000;
        step();
        n_vec++;
        if (DataOut !== 16'h1111) begin
            n_err++;
            $display("FAIL oor_store_dropped: DataOut=%h expected 1111", DataOut);
        end
        idle();
        InstAddr = 16'h8005;
        step();
        n_vec++;
        if (InstOut !== 16'h0000 || AddrFault !== 1'b1) begin
            n_err++;
            $display("FAIL oor_fetch: InstOut=%h AF=%b expected 0000 AF=1", InstOut, AddrFault);
        end
        InstAddr = 16'h0000;
        step();
    endtask

    task automatic test_conflict();
        idle();
        WriteData = 1'b1; DataAddr = 16'h0007; DataIn = 16'h0001;
        LoadEn = 1'b1; LoadAddr = 8'h07; LoadData = 16'h00FF;
        step();
        n_vec++;
        if (Conflict !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_pulse: Conflict=%b expected 1", Conflict);
        end
        idle();
        ReadData = 1'b1; DataAddr = 16'h0007;
        step();
        n_vec++;
        if (DataOut !== 16'h00FF || Conflict !== 1'b0) begin
            n_err++;
            $display("FAIL loader_wins: DataOut=%h Conflict=%b expected 00FF 0", DataOut, Conflict);
        end
        idle();
        WriteData = 1'b1; DataAddr = 16'h0008; DataIn = 16'h3333;
        LoadEn = 1'b1; LoadAddr = 8'h09; LoadData = 16'h4444;
        step();
        n_vec++;
        if (Conflict !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_diff_addr: Conflict=%b expected 1", Conflict);
        end
        idle();
        ReadData = 1'b1; DataAddr = 16'h0008;
        step();
        n_vec++;
        if (DataOut !== 16'h0000) begin
            n_err++;
            $display("FAIL store_displaced: DataOut=%h expected 0000", DataOut);
        end
        DataAddr = 16'h0009;
        step();
        n_vec++;
        if (DataOut !== 16'h4444) begin
            n_err++;
            $display("FAIL loader_diff_addr: DataOut=%h expected 4444", DataOut);
        end
    endtask

    task automatic test_enable();
        idle();
        InstAddr = 16'h0007; ReadData = 1'b1; DataAddr = 16'h0007;
        step();
        Enable = 1'b0; InstAddr = 16'h0008; DataAddr = 16'h0008;
        WriteData = 1'b1; DataIn = 16'hDEAD;
        step();
        n_vec++;
        if (InstOut !== 16'h00FF || DataOut !== 16'h00FF || AddrFault !== 1'b0) begin
            n_err++;
            $display("FAIL enable_hold: InstOut=%h DataOut=%h AF=%b expected 00FF 00FF 0",
                     InstOut, DataOut, AddrFault);
        end
        DataAddr = 16'h0200; InstAddr = 16'h0300;
        step();
        n_vec++;
        if (AddrFault !== 1'b0 || DataOut !== 16'h00FF) begin
            n_err++;
            $display("FAIL enable_no_fault: AF=%b DataOut=%h expected 0 00FF", AddrFault, DataOut);
        end
        idle();
        Enable = 1'b0; LoadEn = 1'b1; LoadAddr = 8'h0A; LoadData = 16'h8888;
        InstAddr = 16'h0000;
        step();
        idle();
        ReadData = 1'b1; DataAddr = 16'h0008;
        step();
        n_vec++;
        if (DataOut !== 16'h0000) begin
            n_err++;
            $display("FAIL disabled_store: DataOut=%h expected 0000", DataOut);
        end
        DataAddr = 16'h000A;
        step();
        n_vec++;
        if (DataOut !== 16'h8888) begin
            n_err++;
            $display("FAIL loader_disabled: DataOut=%h expected 8888", DataOut);
        end
    endtask

    task automatic test_mid_reset();
        int cycles;
        idle();
        WriteData = 1'b1; DataAddr = 16'h0003; DataIn = 16'h5555;
        step();
        idle();
        ReadData = 1'b1; DataAddr = 16'h0003;
        step();
        n_vec++;
        if (DataOut !== 16'h5555) begin
            n_err++;
            $display("FAIL pre_reset_load: DataOut=%h expected 5555", DataOut);
        end
        idle();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_vec++;
        if (Ready !== 1'b0 || DataOut !== 16'h0 || InstOut !== 16'h0) begin
            n_err++;
            $display("FAIL mid_reset: Ready=%b DataOut=%h InstOut=%h expected 0 0000 0000",
                     Ready, DataOut, InstOut);
        end
        cycles = 0;
        while (Ready !== 1'b1 && cycles < 300) begin
            step();
            cycles++;
        end
        n_vec++;
        if (cycles !== 256) begin
            n_err++;
            $display("FAIL reclear_time: Ready after %0d cycles, expected 256", cycles);
        end
        ReadData = 1'b1; DataAddr = 16'h0003;
        step();
        n_vec++;
        if (DataOut !== 16'h0000) begin
            n_err++;
            $display("FAIL reclear_3: DataOut=%h expected 0000", DataOut);
        end
        DataAddr = 16'h0007;
        step();
        n_vec++;
        if (DataOut !== 16'h0000) begin
            n_err++;
            $display("FAIL reclear_7: DataOut=%h expected 0000", DataOut);
        end
        DataAddr = 16'h000A;
        step();
        n_vec++;
        if (DataOut !== 16'h0000) begin
            n_err++;
            $display("FAIL reclear_a: DataOut=%h expected 0000", DataOut);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_forward();
        test_addr_fault();
        test_conflict();
        test_enable();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
# memory_unit

Unified instruction/data memory that sits opposite the processor core. It answers the core's instruction-fetch port and its data load/store port from one word-addressed RAM with a fixed one-cycle read latency. After every reset it runs a hardware clear sequence, and it provides a loader port for programs to be written in before or while the core runs.

## Interface
Parameters:
- WORD_SIZE, 16, data/instruction word width and processor address width
- ADDR_BITS, 8, implemented address bits; DEPTH = 2**ADDR_BITS words

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Enable  in  1  processor-side enable; 0 freezes processor-side reads/writes
- InstAddr  in  WORD_SIZE  instruction fetch address
- InstOut  out  WORD_SIZE  fetched instruction, to core InstIn
- DataAddr  in  WORD_SIZE  load/store address
- DataIn  in  WORD_SIZE  store data, from core DataOut
- WriteData  in  1  store request
- ReadData  in  1  load request
- DataOut  out  WORD_SIZE  load data, to core DataIn
- LoadEn  in  1  loader write strobe
- LoadAddr  in  ADDR_BITS  loader address
- LoadData  in  WORD_SIZE  loader data
- Ready  out  1  1 when clear sequence is done and requests are serviced
- AddrFault  out  1  one-cycle pulse on an out-of-range processor access
- Conflict  out  1  one-cycle pulse when a loader write displaces a processor store

## Operation
- FSM states: CLEAR and RUN. Reset forces CLEAR with clear counter = 0.
- CLEAR:
  - Writes 0 to address counter on each cycle; counter increments.
  - At counter = DEPTH-1 the final word is written and the FSM moves to RUN.
  - Processor and loader requests are ignored.
  - InstOut, DataOut, AddrFault and Conflict are held at 0; Ready = 0.
- RUN, processor side (only when Enable = 1):
  - In-range address means the bits above ADDR_BITS are all 0. The low ADDR_BITS index the array.
  - Store: WriteData = 1 and DataAddr in range writes DataIn.
  - Load: ReadData = 1 registers mem[DataAddr] into DataOut. With ReadData = 0, DataOut holds.
  - Fetch: InstOut registers mem[InstAddr] every enabled cycle.
  - WriteData and ReadData both 1: the store is performed. DataOut returns the new data (write-first).
  - Write-first forwarding also applies to the fetch port. If InstAddr equals the store address in the same cycle, InstOut gets DataIn.
  - Out-of-range load or fetch registers 0. Out-of-range store is dropped. Either case pulses AddrFault for one cycle.
- Enable = 0: InstOut and DataOut hold, no processor stores take place, and AddrFault stays 0.
- Loader (RUN only, independent of Enable):
  - LoadEn = 1 writes LoadData to mem[LoadAddr].
  - If an enabled processor store occurs in the same cycle, the loader wins and the processor store is dropped (even to a different address). Conflict pulses.
  - Write-first forwarding applies to loader writes for both read ports.
- Reset mid-operation returns to CLEAR, and the whole array is cleared again. No prior contents survive reset.

## Timing
- Reset values: InstOut = 0, DataOut = 0, Ready = 0, AddrFault = 0, Conflict = 0, state = CLEAR, counter = 0.
- Clear duration:
  - Reset sampled high at edge R and low from edge R+1.
  - Clear writes occur at edges R+1 through R+DEPTH.
  - Ready = 1 after edge R+DEPTH.
  - The first serviced request is sampled at edge R+DEPTH+1.
- Read latency is 1 cycle. Address presented before edge k gives data on InstOut/DataOut after edge k, stable until the next update.
- Store latency is 1 edge. Data written at edge k is returned by a non-same-cycle read sampled at edge k+1.
- AddrFault and Conflict are registered and assert after the edge that sampled the offending request.

## Structure
- Package mem_pkg:
  - state enum (CLEAR, RUN)
  - default WORD_SIZE and ADDR_BITS constants
  - the in-range check function
- Sub-module mem_array:
  - DEPTH x WORD_SIZE storage with one write port and two synchronous read ports
  - write-first bypass for both read ports
- memory_unit holds the FSM, clear counter, write-port arbitration (clear > loader > processor), range checks and the fault/conflict flags.

## Test plan
- Reset, then wait 256 cycles (default params): Ready rises exactly after edge R+256, and every address reads 0.
- Store 0xBEEF to 0x0012, then load 0x0012 next cycle: DataOut = 0xBEEF one cycle after the load request.
- Same-cycle store 0x1234 and fetch at address 0x0005: InstOut = 0x1234 after that edge. A load at 0x0005 with WriteData = 1 returns 0x1234 the same way.
- Load at DataAddr 0x0100: DataOut = 0 and AddrFault pulses one cycle. Store 0xAAAA to 0x0100: a subsequent load of 0x0000 still returns its old value.
- LoadEn writing 0x00FF → 0x0007 while the processor stores 0x0001 → 0x0007: mem[7] = 0x00FF and Conflict pulses once.
- Store 0x5555 to 0x0003, assert Reset mid-run: Ready drops, then after clear a load of 0x0003 returns 0. With Enable = 0, InstOut/DataOut hold and stores are ignored.
